round_key_sequencer: RTL and testbench
======================================

// Module: round_key_sequencer
// PURPOSE
//   Registers the full expanded-key set produced by ExpandKey and streams it, one
//   128-bit round key per handshake, to the iterative AES round datapath.
//   Sits directly downstream of ExpandKey (AES-128) and upstream of the round engine.
//   Streams in forward order (rounds 0..NR) for encryption and reverse order (NR..0)
//   for decryption. Can replay the buffered key set without reloading it.
// PARAMETERS
//   NR        10   number of AES rounds; NR+1 round keys are buffered
//   RK_BITS   128  width of one round key
// PORTS
//   clock       in   1                single clock; all state updates on posedge
//   reset_n     in   1                asynchronous, active-low reset
//   keyValid    in   1                roundKeys is valid this cycle; load request
//   roundKeys   in   (NR+1)*RK_BITS   roundKeys_t from ExpandKey; key r at bits [r*128 +: 128]
//   decrypt     in   1                direction; sampled only on an accepted load/replay
//   replay      in   1                re-stream the buffered set; no reload
//   rkReady     in   1                round engine accepts roundKey this cycle
//   rkValid     out  1                roundKey/roundIndex valid
//   roundKey    out  RK_BITS          current round key
//   roundIndex  out  4                round number of roundKey (0..NR)
//   lastKey     out  1                current key is the final one of the stream
//   busy        out  1                stream in progress; loads/replays ignored
//   keyLoaded   out  1                buffer holds a valid key set
// BEHAVIOUR
//   Reset (async assert, any state): state=IDLE.
//     rkValid=0, roundKey=0, roundIndex=0, lastKey=0, busy=0, keyLoaded=0.
//     Buffer contents are don't-care.
//     Reset mid-stream aborts the stream immediately; no further keys are emitted.
//   FSM states: IDLE, STREAM.
//   IDLE, keyValid=1:
//     capture all NR+1 keys and decrypt at the edge; keyLoaded=1.
//     Next cycle: STREAM, rkValid=1, idx = decrypt ? NR : 0.
//   IDLE, replay=1 and keyLoaded=1:
//     same as a load, but the buffer is unchanged; decrypt is re-sampled.
//   IDLE, replay=1 and keyLoaded=0: ignored.
//   IDLE, keyValid and replay both high: keyValid wins.
//   Load-to-first-key latency: 1 cycle (keyValid at edge N -> rkValid high after edge N).
//   STREAM:
//     busy=1, rkValid=1, roundKey=buf[idx], roundIndex=idx.
//     lastKey = (idx==NR) when encrypting, (idx==0) when decrypting.
//     rkReady=0: all outputs hold stable (no change while stalled).
//     rkReady=1 and lastKey=0: idx increments (encrypt) or decrements (decrypt) next cycle.
//     rkReady=1 and lastKey=1: -> IDLE; rkValid, busy and lastKey go to 0 next cycle.
//       A new keyValid is accepted from that IDLE cycle.
//   keyValid or replay during STREAM: ignored. Buffer and direction stay frozen.
//     Upstream must wait for busy=0.
//   idx never leaves 0..NR. No wrap-around; the stream terminates at the end key.
//   One key per cycle when rkReady is held high:
//     stream length NR+1 cycles; back-to-back stream gap is 1 IDLE cycle.
//   roundKey is registered; no combinational path from the inputs to the outputs.
// TESTING
//   1. Encrypt stream, FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, rkReady=1:
//      -> 11 keys, idx 0..10; key0 = input key;
//      key10 = d014f9a8c9ee2589e13f0cc8b6630ca6 with lastKey=1; busy=0 next cycle.
//   2. Decrypt stream, same key: first key d014f9a8c9ee2589e13f0cc8b6630ca6 (idx 10),
//      last key 2b7e1516... (idx 0, lastKey=1).
//   3. Backpressure: drop rkReady for 3 cycles at idx 4 -> roundKey/roundIndex stable;
//      resumes at idx 5; total 11 accepted keys.
//   4. keyValid with a different key pulsed mid-stream -> ignored;
//      stream completes with the original keys; keyLoaded stays 1.
//   5. Replay with decrypt=1 after an encrypt stream -> reverse stream of the same keys.
//      Replay right after reset (keyLoaded=0) -> no rkValid.
//   6. reset_n low at idx 6 -> all outputs 0 asynchronously; after release, IDLE with keyLoaded=0.

Source files
------------

// File: rtl/round_key_sequencer.sv
// Buffers one AES expanded-key set and streams its round keys to the round engine,
// forward for encryption and reverse for decryption, with valid/ready flow control.
module round_key_sequencer #(
  parameter int NR      = 10,
  parameter int RK_BITS = 128
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      keyValid,
  input  logic [(NR+1)*RK_BITS-1:0] roundKeys,
  input  logic                      decrypt,
  input  logic                      replay,
  input  logic                      rkReady,
  output logic                      rkValid,
  output logic [RK_BITS-1:0]        roundKey,
  output logic [3:0]                roundIndex,
  output logic                      lastKey,
  output logic                      busy,
  output logic                      keyLoaded
);

  localparam logic [3:0] LP_LAST = 4'(NR);

  typedef enum logic {
    S_IDLE,
    S_STREAM
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [3:0]         r_idx;
  logic [3:0]         w_idx_next;
  logic               r_dec;
  logic               w_dec_next;
  logic               r_last;
  logic               w_last_next;
  logic               r_loaded;
  logic               w_loaded_next;
  logic [RK_BITS-1:0] r_key;
  logic [RK_BITS-1:0] w_key_next;
  logic               w_load;
  logic               w_start;
  logic               w_adv;

  logic [RK_BITS-1:0] r_buf     [0:NR];
  logic [RK_BITS-1:0] w_in_keys [0:NR];

  for (genvar gi = 0; gi <= NR; gi++) begin : g_slice
    assign w_in_keys[gi] = roundKeys[gi*RK_BITS +: RK_BITS];
  end

  // Key storage carries no reset: its contents are meaningless until keyLoaded is set.
  always_ff @(posedge clock) begin
    if (w_load) begin
      for (int r = 0; r <= NR; r++) begin
        r_buf[r] <= w_in_keys[r];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_dec    <= 1'b0;
      r_last   <= 1'b0;
      r_loaded <= 1'b0;
      r_key    <= '0;
    end else begin
      r_state  <= w_state_next;
      r_idx    <= w_idx_next;
      r_dec    <= w_dec_next;
      r_last   <= w_last_next;
      r_loaded <= w_loaded_next;
      r_key    <= w_key_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_idx_next    = r_idx;
    w_dec_next    = r_dec;
    w_loaded_next = r_loaded;
    w_load        = 1'b0;
    w_start       = 1'b0;
    w_adv         = 1'b0;
    w_key_next    = r_key;

    case (r_state)
      S_IDLE: begin
        // A fresh key set takes priority over replaying the buffered one.
        if (keyValid) begin
          w_load        = 1'b1;
          w_start       = 1'b1;
          w_loaded_next = 1'b1;
        end else if (replay && r_loaded) begin
          w_start = 1'b1;
        end
        if (w_start) begin
          w_state_next = S_STREAM;
          w_dec_next   = decrypt;
          w_idx_next   = decrypt ? LP_LAST : 4'd0;
        end
      end
      S_STREAM: begin
        if (rkReady) begin
          if (r_last) begin
            w_state_next = S_IDLE;
          end else begin
            w_adv      = 1'b1;
            w_idx_next = r_dec ? (r_idx - 4'd1) : (r_idx + 4'd1);
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase

    w_last_next = (w_state_next == S_STREAM) &&
                  (w_dec_next ? (w_idx_next == 4'd0) : (w_idx_next == LP_LAST));

    // The first key of a fresh load bypasses the buffer, which is written on the same edge.
    if (w_start || w_adv) begin
      w_key_next = w_load ? w_in_keys[w_idx_next] : r_buf[w_idx_next];
    end
  end

  assign rkValid    = (r_state == S_STREAM);
  assign busy       = (r_state == S_STREAM);
  assign roundKey   = r_key;
  assign roundIndex = r_idx;
  assign lastKey    = r_last;
  assign keyLoaded  = r_loaded;

endmodule

// File: tb/tb_round_key_sequencer.sv
// Self-checking bench: directed vector table, hand-written corner sequences and
// randomized traffic checked against a queue-based stream model.
module tb_round_key_sequencer;
  localparam int NR = 10;
  localparam int KB = 128;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 key_valid = 1'b0;
  logic                 decrypt = 1'b0;
  logic                 replay = 1'b0;
  logic                 rk_ready = 1'b0;
  logic [(NR+1)*KB-1:0] round_keys = '0;
  logic                 rkValid;
  logic [KB-1:0]        roundKey;
  logic [3:0]           roundIndex;
  logic                 lastKey;
  logic                 busy;
  logic                 keyLoaded;

  round_key_sequencer #(.NR(NR), .RK_BITS(KB)) dut (
    .clock      (clk),
    .reset_n    (rst_n),
    .keyValid   (key_valid),
    .roundKeys  (round_keys),
    .decrypt    (decrypt),
    .replay     (replay),
    .rkReady    (rk_ready),
    .rkValid    (rkValid),
    .roundKey   (roundKey),
    .roundIndex (roundIndex),
    .lastKey    (lastKey),
    .busy       (busy),
    .keyLoaded  (keyLoaded)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_hs = 0;
  bit mon_en = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // FIPS-197 Appendix A.1 expansion of 2b7e151628aed2a6abf7158809cf4f3c
  logic [127:0] fips [0:NR];

  task automatic load_fips();
    for (int r = 0; r <= NR; r++) round_keys[r*KB +: KB] = fips[r];
  endtask

  task automatic load_random();
    for (int w = 0; w < (NR+1)*4; w++) round_keys[w*32 +: 32] = $urandom;
  endtask

  // Reference model: an accepted start enqueues the whole expected stream; each handshake pops one.
  typedef struct {
    logic [3:0]   idx;
    logic [127:0] key;
  } exp_t;

  logic [127:0] m_buf [0:NR];
  bit           m_loaded = 1'b0;
  exp_t         m_q[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_loaded = 1'b0;
    end else if (m_q.size() != 0) begin
      if (rk_ready) begin
        $display("key  idx=%0d key=%h last=%0d", m_q[0].idx, m_q[0].key, m_q.size() == 1);
        void'(m_q.pop_front());
        n_hs++;
      end
    end else if (key_valid || (replay && m_loaded)) begin
      if (key_valid) begin
        for (int r = 0; r <= NR; r++) m_buf[r] = round_keys[r*KB +: KB];
        m_loaded = 1'b1;
      end
      for (int i = 0; i <= NR; i++) begin
        int r;
        exp_t e;
        r = decrypt ? NR - i : i;
        e.idx = 4'(r);
        e.key = m_buf[r];
        m_q.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      check("mon_rkValid", rkValid, m_q.size() != 0);
      check("mon_busy", busy, m_q.size() != 0);
      check("mon_keyLoaded", keyLoaded, m_loaded);
      if (m_q.size() != 0) begin
        check("mon_roundKey", roundKey, m_q[0].key);
        check("mon_roundIndex", roundIndex, m_q[0].idx);
        check("mon_lastKey", lastKey, m_q.size() == 1);
      end
    end
  end

  typedef struct {
    bit kv;
    bit dec;
    bit rdy;
    bit e_valid;
    int e_idx;
    bit e_last;
  } vec_t;

  vec_t tbl [15];

  initial begin
    int hs0;
    logic [127:0] first_key;

    fips[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fips[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    // Encrypt load with rkReady low, then 3 stall cycles while idx 4 is presented.
    tbl[0]  = '{1, 0, 0, 1, 0, 0};
    tbl[1]  = '{0, 0, 1, 1, 1, 0};
    tbl[2]  = '{0, 0, 1, 1, 2, 0};
    tbl[3]  = '{0, 0, 1, 1, 3, 0};
    tbl[4]  = '{0, 0, 1, 1, 4, 0};
    tbl[5]  = '{0, 0, 0, 1, 4, 0};
    tbl[6]  = '{0, 0, 0, 1, 4, 0};
    tbl[7]  = '{0, 0, 0, 1, 4, 0};
    tbl[8]  = '{0, 0, 1, 1, 5, 0};
    tbl[9]  = '{0, 0, 1, 1, 6, 0};
    tbl[10] = '{0, 0, 1, 1, 7, 0};
    tbl[11] = '{0, 0, 1, 1, 8, 0};
    tbl[12] = '{0, 0, 1, 1, 9, 0};
    tbl[13] = '{0, 0, 1, 1, 10, 1};
    tbl[14] = '{0, 0, 1, 0, 0, 0};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_rkValid", rkValid, 0);
    check("rst_roundKey", roundKey, 0);
    check("rst_roundIndex", roundIndex, 0);
    check("rst_lastKey", lastKey, 0);
    check("rst_busy", busy, 0);
    check("rst_keyLoaded", keyLoaded, 0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    // Encrypt stream, rkReady held high
    load_fips();
    decrypt = 1'b0; key_valid = 1'b1; rk_ready = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    for (int i = 0; i <= NR; i++) begin
      check("enc_idx", roundIndex, i);
      check("enc_key", roundKey, fips[i]);
      check("enc_last", lastKey, i == NR);
      if (i == NR) check("enc_key10", roundKey, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      else @(negedge clk);
    end
    @(negedge clk);
    check("enc_end_busy", busy, 0);
    check("enc_end_valid", rkValid, 0);

    // Decrypt stream started from the single IDLE cycle (back-to-back)
    decrypt = 1'b1; key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    check("dec_first_valid", rkValid, 1);
    check("dec_first_key", roundKey, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check("dec_first_idx", roundIndex, NR);
    repeat (NR) @(negedge clk);
    check("dec_last_key", roundKey, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    check("dec_last_idx", roundIndex, 0);
    check("dec_last_flag", lastKey, 1);
    @(negedge clk);
    check("dec_end_busy", busy, 0);

    // Vector table: backpressure at idx 4
    hs0 = n_hs;
    for (int k = 0; k < 15; k++) begin
      key_valid = tbl[k].kv;
      decrypt = tbl[k].dec;
      rk_ready = tbl[k].rdy;
      @(negedge clk);
      check("tbl_valid", rkValid, tbl[k].e_valid);
      check("tbl_busy", busy, tbl[k].e_valid);
      if (tbl[k].e_valid) begin
        check("tbl_idx", roundIndex, tbl[k].e_idx);
        check("tbl_key", roundKey, fips[tbl[k].e_idx]);
        check("tbl_last", lastKey, tbl[k].e_last);
      end
    end
    key_valid = 1'b0;
    check("tbl_accepted", n_hs - hs0, NR + 1);

    // keyValid with a different key mid-stream is ignored
    load_fips();
    decrypt = 1'b0; key_valid = 1'b1; rk_ready = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    repeat (3) @(negedge clk);
    load_random();
    key_valid = 1'b1; decrypt = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    for (int i = 4; i <= NR; i++) begin
      check("midload_key", roundKey, fips[i]);
      check("midload_idx", roundIndex, i);
      if (i < NR) @(negedge clk);
    end
    check("midload_loaded", keyLoaded, 1);
    @(negedge clk);

    // Replay in reverse without reloading (input bus holds unrelated data)
    load_random();
    replay = 1'b1; decrypt = 1'b1;
    @(negedge clk);
    replay = 1'b0;
    for (int i = NR; i >= 0; i--) begin
      check("replay_key", roundKey, fips[i]);
      check("replay_idx", roundIndex, i);
      if (i > 0) @(negedge clk);
    end
    @(negedge clk);

    // Asynchronous reset while idx 6 is presented
    load_fips();
    decrypt = 1'b0; key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("pre_rst_idx", roundIndex, 6);
    #2 rst_n = 1'b0;
    #1;
    check("arst_rkValid", rkValid, 0);
    check("arst_roundKey", roundKey, 0);
    check("arst_roundIndex", roundIndex, 0);
    check("arst_lastKey", lastKey, 0);
    check("arst_busy", busy, 0);
    check("arst_keyLoaded", keyLoaded, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Replay with nothing loaded must not start a stream
    replay = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("replay_empty_valid", rkValid, 0);
      check("replay_empty_loaded", keyLoaded, 0);
    end
    replay = 1'b0;

    // Randomized traffic checked by the model
    for (int c = 0; c < 500; c++) begin
      key_valid = ($urandom_range(0, 7) == 0);
      replay = ($urandom_range(0, 5) == 0);
      decrypt = $urandom_range(0, 1) == 1;
      rk_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) load_random();
      @(negedge clk);
    end
    key_valid = 1'b0; replay = 1'b0; rk_ready = 1'b1;
    repeat (2 * (NR + 2)) @(negedge clk);
    check("final_idle", busy, 0);
    first_key = fips[0];
    check("fips_table_intact", first_key, 128'h2b7e151628aed2a6abf7158809cf4f3c);

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
